imem_loader_run_ctrl: RTL

- Drives the MIPS core instead of observing it.
- Streams a program into instruction memory through a valid/ready word interface.
- Holds the core in reset during load, then releases it at a programmed start PC.
- Counts core clock cycles and freezes the core after a programmed cycle budget, so register-file contents stay stable for readout.

---
 rtl/imem_loader_run_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/imem_loader_run_ctrl.sv
// Program loader and run controller for a MIPS core: streams words into instruction
// memory, releases the core at a chosen PC, and freezes it after a cycle budget.
module imem_loader_run_ctrl #(
    parameter int MAX_WORDS = 256,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   start_pc,
    input  logic [CW-1:0] run_cycles,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          imem_we,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_rst_n,
    output logic          cpu_hold,
    output logic [31:0]   cpu_pc_init,
    output logic [CW-1:0] cycle_count,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int WCW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t        state_q;
    logic [31:0]   ptr_q;
    logic [WCW-1:0] cnt_q;
    logic [CW-1:0] budget_q;
    logic [CW-1:0] cycle_q;
    logic [31:0]   pc_init_q;
    logic          cpu_rst_n_q;
    logic          cpu_hold_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;

    logic           accept;
    logic [WCW-1:0] cnt_d;
    logic           budget_hit;

    // The write port is combinational so a word lands in memory in its handshake cycle.
    assign load_ready = (state_q == S_LOAD);
    assign accept     = load_ready & load_valid;
    assign imem_we    = accept;
    assign imem_addr  = accept ? ptr_q : 32'd0;
    assign imem_wdata = accept ? load_data : 32'd0;

    assign cnt_d      = cnt_q + WCW'(1);
    assign budget_hit = (budget_q != '0) && (cycle_q == budget_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= 32'd0;
            cnt_q       <= '0;
            budget_q    <= '0;
            cycle_q     <= '0;
            pc_init_q   <= 32'd0;
            cpu_rst_n_q <= 1'b0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            error_q <= 1'b0;
            // A handshake that coincides with abort still counts as a completed write.
            if (accept) begin
                ptr_q <= ptr_q + 32'd4;
                cnt_q <= cnt_d;
            end
            if (abort) begin
                state_q     <= S_IDLE;
                cpu_rst_n_q <= 1'b0;
                cpu_hold_q  <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_HALT: begin
                        if (start) begin
                            if (start_pc[1:0] != 2'b00) begin
                                error_q <= 1'b1;
                            end else begin
                                state_q     <= S_LOAD;
                                ptr_q       <= start_pc;
                                pc_init_q   <= start_pc;
                                budget_q    <= run_cycles;
                                cnt_q       <= '0;
                                cycle_q     <= '0;
                                cpu_rst_n_q <= 1'b0;
                                cpu_hold_q  <= 1'b0;
                                busy_q      <= 1'b1;
                                done_q      <= 1'b0;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            if (load_last) begin
                                state_q <= S_SETTLE;
                            end else if (cnt_d == WCW'(MAX_WORDS)) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_SETTLE: begin
                        // Counter leaves this cycle at 1 so the first RUN cycle reads 1.
                        state_q     <= S_RUN;
                        cpu_rst_n_q <= 1'b1;
                        cycle_q     <= cycle_q + CW'(1);
                    end
                    S_RUN: begin
                        if (budget_hit) begin
                            state_q    <= S_HALT;
                            cpu_hold_q <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else if (cycle_q != '1) begin
                            cycle_q <= cycle_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        cpu_rst_n_q <= 1'b0;
                        cpu_hold_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cpu_rst_n   = cpu_rst_n_q;
    assign cpu_hold    = cpu_hold_q;
    assign cpu_pc_init = pc_init_q;
    assign cycle_count = cycle_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
